nonlinear_tile_sched: RTL and testbench

Job-level scheduler that shares one `nonlinear_tile` (Softplus/Exp) datapath between two requesters: the Softplus path (delta, 256×1) and the Exp path (256×16). It arbitrates whole jobs round-robin and drives `mode` and the `valid_in` pulses. It steps the granted requester through N_TILE tiles using a fetch/issue/wait/retire handshake, and aborts a job if `done_tile` never arrives. The operand and result buses run directly between the requesters and the datapath; this block carries control only.

---
 rtl/nonlinear_tile_sched_if.sv | 33 +++
 rtl/nonlinear_tile_sched.sv | 99 +++++++++
 tb/tb_nonlinear_tile_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nonlinear_tile_sched_if.sv
// rtl/nonlinear_tile_sched_if.sv - requester/datapath control bundle for nonlinear_tile_sched
// master is the scheduler side, slave is the requester/datapath side.
interface nonlinear_tile_sched_if #(
   parameter int TILE_IDX_W = 4
);
   logic                  sp_req;
   logic                  exp_req;
   logic                  sp_gnt;
   logic                  exp_gnt;
   logic                  tile_req;
   logic                  tile_rdy;
   logic [TILE_IDX_W-1:0] tile_idx;
   logic                  nl_valid_in;
   logic                  nl_mode;
   logic                  nl_done_tile;
   logic                  tile_done;
   logic                  job_done;
   logic                  busy;
   logic                  timeout_err;
   logic                  clear_err;

   modport master (
      input  sp_req, exp_req, tile_rdy, nl_done_tile, clear_err,
      output sp_gnt, exp_gnt, tile_req, tile_idx, nl_valid_in, nl_mode,
             tile_done, job_done, busy, timeout_err
   );

   modport slave (
      output sp_req, exp_req, tile_rdy, nl_done_tile, clear_err,
      input  sp_gnt, exp_gnt, tile_req, tile_idx, nl_valid_in, nl_mode,
             tile_done, job_done, busy, timeout_err
   );
endinterface

// File: rtl/nonlinear_tile_sched.sv
// rtl/nonlinear_tile_sched.sv - round-robin job scheduler for the shared Softplus/Exp tile datapath
// Outputs are registered decodes of the next state, so they line up with the state they describe.
module nonlinear_tile_sched #(
   parameter int N_TILE     = 16,
   parameter int TILE_IDX_W = 4,
   parameter int TIMEOUT    = 64
) (
   input logic                    clk,
   input logic                    rst_n,
   nonlinear_tile_sched_if.master bus
);
   localparam int WAIT_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_RETIRE, S_DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              rr_last;   // 1 = Exp was served last
   logic [WAIT_W-1:0] wait_cnt;
   logic              pick_exp;
   logic              timeout_hit;
   logic              last_tile;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      pick_exp    = 1'b0;
      timeout_hit = 1'b0;
      last_tile   = (bus.tile_idx == TILE_IDX_W'(N_TILE - 1));
      case (state)
         S_IDLE: begin
            pick_exp = bus.exp_req && (!bus.sp_req || !rr_last);
            if (bus.sp_req || bus.exp_req) next_state = S_FETCH;
         end
         S_FETCH:  if (bus.tile_rdy) next_state = S_ISSUE;
         S_ISSUE:  next_state = S_WAIT;
         S_WAIT: begin
            if (bus.nl_done_tile) begin
               next_state = S_RETIRE;
            end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               next_state  = S_DONE;
            end
         end
         S_RETIRE: next_state = last_tile ? S_DONE : S_FETCH;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sp_gnt      <= 1'b0;
         bus.exp_gnt     <= 1'b0;
         bus.tile_req    <= 1'b0;
         bus.tile_idx    <= '0;
         bus.nl_valid_in <= 1'b0;
         bus.nl_mode     <= 1'b0;
         bus.tile_done   <= 1'b0;
         bus.job_done    <= 1'b0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= 1'b0;
         rr_last         <= 1'b1;
         wait_cnt        <= '0;
      end else begin
         bus.tile_req    <= (next_state == S_FETCH);
         bus.nl_valid_in <= (next_state == S_ISSUE);
         bus.tile_done   <= (next_state == S_RETIRE);
         bus.job_done    <= (next_state == S_DONE);
         bus.busy        <= (next_state != S_IDLE);

         if (state == S_IDLE && next_state == S_FETCH) begin
            bus.sp_gnt   <= !pick_exp;
            bus.exp_gnt  <= pick_exp;
            bus.nl_mode  <= pick_exp;
            bus.tile_idx <= '0;
         end else if (state == S_DONE) begin
            bus.sp_gnt  <= 1'b0;
            bus.exp_gnt <= 1'b0;
            rr_last     <= bus.exp_gnt;
         end

         if (state == S_RETIRE && !last_tile) bus.tile_idx <= bus.tile_idx + 1'b1;

         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

         // A new timeout takes priority over a simultaneous clear.
         if (timeout_hit)        bus.timeout_err <= 1'b1;
         else if (bus.clear_err) bus.timeout_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_nonlinear_tile_sched.sv
// tb/tb_nonlinear_tile_sched.sv - self-checking bench for nonlinear_tile_sched
// Job-level scoreboard plus per-cycle rule checks, with requester and datapath models.
module tb_nonlinear_tile_sched;
   localparam int N_TILE = 16;

   logic clk;
   logic rst_n;

   nonlinear_tile_sched_if #(.TILE_IDX_W(4)) bus();

   nonlinear_tile_sched #(.N_TILE(N_TILE), .TILE_IDX_W(4), .TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Expected jobs: owner (1 = Exp), length FETCH..DONE in cycles, tiles retired, timeout flag.
   int e_exp   [16];
   int e_len   [16];
   int e_tiles [16];
   int e_to    [16];
   int n_pushed = 0;
   int n_popped = 0;

   int sp_target = 0, exp_target = 0, sp_served = 0, exp_served = 0;
   int slow_tile = -1, stall_tile = -1, lat = 2;
   bit idle_spur = 0, issue_spur = 0;

   task automatic check(input string name, input int act, input int req);
      n_total = n_total + 1;
      if (act == req) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d, want %0d", name, act, req);
   endtask

   task automatic push(input int owner, input int len, input int tiles, input int to);
      e_exp[n_pushed]   = owner;
      e_len[n_pushed]   = len;
      e_tiles[n_pushed] = tiles;
      e_to[n_pushed]    = to;
      n_pushed = n_pushed + 1;
   endtask

   task automatic wait_jobs(input int budget);
      int k = 0;
      while (n_popped < n_pushed && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check("jobs_complete", n_popped, n_pushed);
   endtask

   task automatic observe_job(output int done_at, output int nv, output int nd,
                              output int nsp, output int nexp, output int nreq5, output int nval5);
      done_at = -1; nv = 0; nd = 0; nsp = 0; nexp = 0; nreq5 = 0; nval5 = 0;
      for (int c = 1; c <= 300 && done_at < 0; c++) begin
         @(posedge clk); #1;
         nv    += int'(bus.nl_valid_in);
         nd    += int'(bus.tile_done);
         nsp   += int'(bus.sp_gnt);
         nexp  += int'(bus.exp_gnt);
         nreq5 += int'(bus.tile_req && bus.tile_idx == 4'd5);
         nval5 += int'(bus.nl_valid_in && bus.tile_idx == 4'd5);
         if (bus.job_done) done_at = c;
      end
   endtask

   // Requesters: hold req until enough of their jobs have finished.
   initial begin
      bus.sp_req  = 1'b0;
      bus.exp_req = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.job_done) begin
            if (bus.sp_gnt)  sp_served++;
            if (bus.exp_gnt) exp_served++;
         end
         bus.sp_req  = (sp_served < sp_target);
         bus.exp_req = (exp_served < exp_target);
      end
   end

   // Operand side: tile_rdy after an extra delay on the slow tile.
   initial begin
      int run = 0;
      bus.tile_rdy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.tile_req) begin
            bus.tile_rdy = (run >= ((int'(bus.tile_idx) == slow_tile) ? 3 : 0));
            run++;
         end else begin
            run = 0;
            bus.tile_rdy = 1'b0;
         end
      end
   end

   // Datapath: done_tile lat cycles after valid_in, never for the stalled tile.
   initial begin
      int cd = 0;
      bus.nl_done_tile = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.nl_done_tile = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) bus.nl_done_tile = 1'b1;
         end
         if (bus.nl_valid_in) begin
            if (issue_spur) bus.nl_done_tile = 1'b1;
            if (int'(bus.tile_idx) != stall_tile) cd = lat;
         end
         if (idle_spur && !bus.busy) bus.nl_done_tile = 1'b1;
      end
   end

   // Per-cycle checker against the job scoreboard.
   initial begin
      bit in_job = 0, issue_pending = 0, prev_valid = 0;
      int job_cycles = 0, tiles = 0, next_tile = 0, req_run = 0, want_idx;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            if (in_job) n_popped = n_popped + 1;
            in_job = 0; issue_pending = 0; req_run = 0; prev_valid = 0;
         end else begin
            check("gnt_onehot", int'(bus.sp_gnt & bus.exp_gnt), 0);
            check("busy_vs_gnt", int'(bus.busy), int'(bus.sp_gnt | bus.exp_gnt));
            check("valid_spacing", int'(bus.nl_valid_in & prev_valid), 0);
            prev_valid = bus.nl_valid_in;
            if (!bus.busy) begin
               check("idle_quiet", int'({bus.tile_req, bus.nl_valid_in, bus.tile_done, bus.job_done}), 0);
            end else begin
               if (!in_job) begin
                  in_job = 1; job_cycles = 0; tiles = 0; next_tile = 0;
                  issue_pending = 0; req_run = 0;
               end
               job_cycles++;
               check("job_expected", int'(n_popped < n_pushed), 1);
               if (n_popped < n_pushed) begin
                  check("owner_exp_gnt", int'(bus.exp_gnt), e_exp[n_popped]);
                  check("nl_mode", int'(bus.nl_mode), e_exp[n_popped]);
               end
               want_idx = (next_tile > N_TILE - 1) ? N_TILE - 1 : next_tile;
               check("tile_idx", int'(bus.tile_idx), want_idx);
               if (bus.tile_req) req_run++;
               if (bus.nl_valid_in) begin
                  check("fetch_len", req_run, (next_tile == slow_tile) ? 4 : 1);
                  req_run = 0;
                  issue_pending = 1;
               end
               if (bus.tile_done) begin
                  check("done_after_issue", int'(issue_pending), 1);
                  issue_pending = 0;
                  tiles++;
                  next_tile++;
               end
               if (bus.job_done) begin
                  if (n_popped < n_pushed) begin
                     check("job_len", job_cycles, e_len[n_popped]);
                     check("job_tiles", tiles, e_tiles[n_popped]);
                     check("job_timeout_err", int'(bus.timeout_err), e_to[n_popped]);
                  end
                  n_popped = n_popped + 1;
                  in_job = 0;
               end
            end
         end
      end
   end

   initial begin
      int done_at, nv, nd, nsp, nexp, nreq5, nval5, k;
      rst_n = 1'b0;
      bus.clear_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({bus.sp_gnt, bus.exp_gnt, bus.tile_req, bus.nl_valid_in,
            bus.tile_done, bus.job_done, bus.busy, bus.timeout_err, bus.nl_mode, bus.tile_idx}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Both requesters pending: Softplus first (rr_last resets to Exp), then alternate.
      push(0, 81, 16, 0); push(1, 81, 16, 0); push(0, 81, 16, 0);
      sp_target = 2; exp_target = 1;
      wait_jobs(600);

      // Single Softplus job, tile_rdy tied high, L = 2.
      push(0, 81, 16, 0);
      sp_target = 3;
      observe_job(done_at, nv, nd, nsp, nexp, nreq5, nval5);
      check("t1_job_done_cycle", done_at, 81);
      check("t1_valid_pulses", nv, 16);
      check("t1_tile_done", nd, 16);
      check("t1_sp_gnt_cycles", nsp, 81);
      check("t1_exp_gnt_cycles", nexp, 0);
      wait_jobs(50);

      // Operands for tile 5 arrive 3 cycles late.
      slow_tile = 5;
      push(0, 84, 16, 0);
      sp_target = 4;
      observe_job(done_at, nv, nd, nsp, nexp, nreq5, nval5);
      check("t3_job_done_cycle", done_at, 84);
      check("t3_tile5_req_cycles", nreq5, 4);
      check("t3_tile5_valid", nval5, 1);
      check("t3_valid_pulses", nv, 16);
      wait_jobs(50);
      slow_tile = -1;

      // Datapath never answers tile 7: 7 tiles of 5, then 1+1+64 cycles, then DONE.
      stall_tile = 7;
      push(1, 102, 7, 1);
      exp_target = 2;
      wait_jobs(400);
      stall_tile = -1;
      @(posedge clk); #1;
      check("t4_timeout_err_sticky", int'(bus.timeout_err), 1);
      check("t4_gnt_dropped", int'({bus.sp_gnt, bus.exp_gnt}), 0);
      bus.clear_err = 1'b1;
      @(posedge clk); #1;
      bus.clear_err = 1'b0;
      check("t4_timeout_err_cleared", int'(bus.timeout_err), 0);

      // Spurious done_tile while idle and during ISSUE must be ignored.
      idle_spur = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t5_idle_busy", int'(bus.busy), 0);
      end
      idle_spur = 0;
      issue_spur = 1;
      push(0, 81, 16, 0);
      sp_target = 5;
      wait_jobs(400);
      issue_spur = 0;

      // Reset during the WAIT of tile 3 discards the job; the held req restarts it.
      push(0, 81, 16, 0); push(0, 81, 16, 0);
      sp_target = 6;
      k = 0;
      while (!(bus.nl_valid_in && bus.tile_idx == 4'd3) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("t6_reached_tile3", int'(k < 200), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t6_reset_outputs", int'({bus.sp_gnt, bus.exp_gnt, bus.tile_req, bus.nl_valid_in,
            bus.tile_done, bus.job_done, bus.busy, bus.timeout_err, bus.nl_mode, bus.tile_idx}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_jobs(400);
      check("t6_sp_jobs_served", sp_served, 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
